// File: rtl/timebase_gen.sv
// Time-base generator: divides the system clock into one-cycle second,
// minute and hour strobes and exposes running second/minute counts.
// Supports hold (freeze) plus fastwatch and turbo test modes.
module timebase_gen #(
  parameter int unsigned TICKS_PER_SEC = 256,
  parameter int unsigned SECS_PER_MIN  = 60,
  parameter int unsigned MINS_PER_HOUR = 60
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             reset_count,
  input  logic                             hold,
  input  logic [1:0]                       mode,
  output logic                             one_second,
  output logic                             one_minute,
  output logic                             one_hour,
  output logic [$clog2(SECS_PER_MIN)-1:0]  sec_count,
  output logic [$clog2(MINS_PER_HOUR)-1:0] min_count
);

  localparam int unsigned TW = $clog2(TICKS_PER_SEC);
  localparam int unsigned SW = $clog2(SECS_PER_MIN);
  localparam int unsigned MW = $clog2(MINS_PER_HOUR);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(SECS_PER_MIN - 1);
  localparam logic [MW-1:0] MIN_LAST  = MW'(MINS_PER_HOUR - 1);

  localparam logic [1:0] MODE_FAST  = 2'b01;
  localparam logic [1:0] MODE_TURBO = 2'b10;

  logic [TW-1:0] tick_cnt;
  logic          sec_r;
  logic          min_r;
  logic          hr_r;
  logic          tick_wrap;
  logic          sec_wrap;
  logic          min_wrap;

  // Wrap detection; turbo forces a second boundary on every cycle
  always_comb begin
    tick_wrap = 1'b0;
    sec_wrap  = 1'b0;
    min_wrap  = 1'b0;
    if (!hold) begin
      tick_wrap = (mode == MODE_TURBO) ? 1'b1 : (tick_cnt == TICK_LAST);
    end
    sec_wrap = tick_wrap && (sec_count == SEC_LAST);
    min_wrap = sec_wrap && (min_count == MIN_LAST);
  end

  // Counter chain and strobe registers; reset > reset_count > hold > count
  always_ff @(posedge clock) begin
    if (!reset_n || reset_count) begin
      tick_cnt  <= '0;
      sec_count <= '0;
      min_count <= '0;
      sec_r     <= 1'b0;
      min_r     <= 1'b0;
      hr_r      <= 1'b0;
    end else if (hold) begin
      sec_r <= 1'b0;
      min_r <= 1'b0;
      hr_r  <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
      if (tick_wrap) begin
        sec_count <= sec_wrap ? '0 : sec_count + SW'(1);
      end
      if (sec_wrap) begin
        min_count <= min_wrap ? '0 : min_count + MW'(1);
      end
      sec_r <= tick_wrap;
      min_r <= sec_wrap;
      hr_r  <= min_wrap;
    end
  end

  // Strobe output mux; fastwatch shifts minute/hour strobes down one level
  always_comb begin
    one_second = sec_r;
    one_minute = min_r;
    one_hour   = hr_r;
    if (mode == MODE_FAST) begin
      one_minute = sec_r;
      one_hour   = min_r;
    end
  end

endmodule

// File: tb/tb_timebase_gen.sv
// Bench for timebase_gen: a small-parameter instance driven from a vector
// table, plus directed multi-cycle sequences on the default instance.
module tb_timebase_gen;

  logic       clock;
  logic       reset_n;
  logic       reset_count;
  logic       hold;
  logic [1:0] mode;

  logic       d_os, d_om, d_oh;
  logic [5:0] d_sc, d_mc;
  logic       s_os, s_om, s_oh;
  logic [1:0] s_sc;
  logic [0:0] s_mc;

  int total = 0;
  int bad   = 0;

  timebase_gen u_def (
    .clock(clock), .reset_n(reset_n), .reset_count(reset_count), .hold(hold), .mode(mode),
    .one_second(d_os), .one_minute(d_om), .one_hour(d_oh), .sec_count(d_sc), .min_count(d_mc)
  );

  timebase_gen #(.TICKS_PER_SEC(4), .SECS_PER_MIN(3), .MINS_PER_HOUR(2)) u_small (
    .clock(clock), .reset_n(reset_n), .reset_count(reset_count), .hold(hold), .mode(mode),
    .one_second(s_os), .one_minute(s_om), .one_hour(s_oh), .sec_count(s_sc), .min_count(s_mc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rn, rc, hd;
    logic [1:0] md;
    int         ncyc;
    int         os, om, oh, sc, mc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rn, input logic rc, input logic hd, input logic [1:0] md,
                              input int ncyc, input int os, input int om, input int oh,
                              input int sc, input int mc);
    vec_t v;
    v.rn = rn; v.rc = rc; v.hd = hd; v.md = md; v.ncyc = ncyc;
    v.os = os; v.om = om; v.oh = oh; v.sc = sc; v.mc = mc;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; reset_count = 1'b0; hold = 1'b0;
    step(1);
    reset_n = 1'b1;
  endtask

  initial begin
    int errs, errs2, errs3, k;
    reset_n = 1'b0; reset_count = 1'b0; hold = 1'b0; mode = 2'b00;

    // Small instance: TPS=4, SPM=3, MPH=2. ncyc=0 means settle without a clock edge.
    //                 rn    rc    hd    md    n   os om oh sc mc
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0,  1,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  3,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  1,  1, 0, 0, 1, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  1,  0, 0, 0, 1, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  7,  1, 1, 0, 0, 1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 12,  1, 1, 1, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  1,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  2,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0,  3,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  1,  1, 0, 0, 1, 0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0,  1,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  3,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,  1,  1, 0, 0, 1, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd1,  0,  1, 1, 0, 1, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd1,  4,  1, 1, 0, 2, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd1,  4,  1, 1, 1, 0, 1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd1,  1,  0, 0, 0, 0, 1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2,  1,  1, 0, 0, 1, 1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2,  1,  1, 0, 0, 2, 1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2,  1,  1, 1, 1, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd3,  3,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd3,  1,  1, 0, 0, 1, 0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 2'd0,  1,  0, 0, 0, 0, 0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2,  2,  1, 0, 0, 2, 0));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 2'd2,  1,  0, 0, 0, 0, 0));

    #1;
    foreach (vq[i]) begin
      reset_n = vq[i].rn; reset_count = vq[i].rc; hold = vq[i].hd; mode = vq[i].md;
      if (vq[i].ncyc > 0) step(vq[i].ncyc);
      else #1;
      chk($sformatf("v%0d_one_second", i), int'(s_os), vq[i].os);
      chk($sformatf("v%0d_one_minute", i), int'(s_om), vq[i].om);
      chk($sformatf("v%0d_one_hour", i),   int'(s_oh), vq[i].oh);
      chk($sformatf("v%0d_sec_count", i),  int'(s_sc), vq[i].sc);
      chk($sformatf("v%0d_min_count", i),  int'(s_mc), vq[i].mc);
    end

    // A: default params, normal mode, one full minute from reset
    mode = 2'b00;
    do_reset();
    errs = 0; errs2 = 0; errs3 = 0;
    for (int c = 1; c <= 15360; c++) begin
      step(1);
      if (int'(d_os) != ((c % 256 == 0) ? 1 : 0)) errs++;
      if (c < 15360 && d_om) errs2++;
      if (int'(d_sc) > 59 || int'(d_sc) != (c / 256) % 60) errs3++;
    end
    chk("A_second_pattern", errs, 0);
    chk("A_minute_early", errs2, 0);
    chk("A_sec_count_track", errs3, 0);
    chk("A_minute_at_15360", int'(d_om), 1);
    chk("A_sec_count_at_minute", int'(d_sc), 0);
    chk("A_min_count_at_minute", int'(d_mc), 1);
    chk("A_no_hour", int'(d_oh), 0);

    // B: reset_count at tick 100 of second 5 restarts the full second
    do_reset();
    step(5 * 256);
    chk("B_sec_count_5", int'(d_sc), 5);
    step(100);
    reset_count = 1'b1;
    step(1);
    chk("B_sec_cleared", int'(d_sc), 0);
    chk("B_no_stale_strobe", int'(d_os), 0);
    reset_count = 1'b0;
    k = 0;
    do begin step(1); k++; end while (!d_os && k < 400);
    chk("B_second_latency", k, 256);

    // C: hold for 50 clocks at tick 200 of second 1
    do_reset();
    step(256 + 200);
    chk("C_sec_count_pre", int'(d_sc), 1);
    hold = 1'b1;
    errs = 0; errs2 = 0;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (d_os || d_om || d_oh) errs++;
      if (int'(d_sc) != 1) errs2++;
    end
    chk("C_hold_no_strobe", errs, 0);
    chk("C_hold_sec_frozen", errs2, 0);
    hold = 1'b0;
    k = 0;
    do begin step(1); k++; end while (!d_os && k < 400);
    chk("C_second_after_hold", 50 + k, 106);
    chk("C_sec_count_post", int'(d_sc), 2);

    // D: fastwatch mirrors the second strobe onto one_minute
    mode = 2'b01;
    do_reset();
    errs = 0; errs2 = 0; errs3 = 0;
    for (int c = 1; c <= 600; c++) begin
      step(1);
      if (d_om != d_os) errs++;
      if (d_os) errs2++;
      if (d_oh) errs3++;
    end
    chk("D_minute_mirrors_second", errs, 0);
    chk("D_second_count", errs2, 2);
    chk("D_hour_quiet", errs3, 0);

    // E: turbo from reset on the small instance, then reset_n mid-run
    mode = 2'b10;
    do_reset();
    errs = 0;
    for (int c = 1; c <= 9; c++) begin
      step(1);
      if (!s_os) errs++;
      if (int'(s_om) != ((c % 3 == 0) ? 1 : 0)) errs++;
      if (int'(s_oh) != ((c % 6 == 0) ? 1 : 0)) errs++;
    end
    chk("E_turbo_strobes", errs, 0);
    reset_n = 1'b0;
    step(1);
    chk("E_reset_small", int'({s_os, s_om, s_oh, s_sc, s_mc}), 0);
    chk("E_reset_default", int'({d_os, d_om, d_oh, d_sc, d_mc}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
